// File: rtl/word_delay_line_pkg.sv
// Shared defaults and helpers for the word delay line.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package word_delay_line_pkg;

    // Default geometry: byte-wide words, twelve word stages.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 12;

    // Select width that stays at least one bit wide, so a single-stage line
    // still has a real tap select port.
    function automatic int clog2_min1(input int n);
        int r;
        r = (n <= 1) ? 1 : $clog2(n);
        return r;
    endfunction

endpackage

// File: rtl/word_delay_line_bit_packer.sv
// Packs valid-strobed serial bits into WIDTH-bit words, MSB-first or LSB-first.
// Latency: word_vld/word_dat are combinational on the edge that accepts the last bit.
// Backpressure: none; every strobed bit is accepted, and idle cycles hold state.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clr             synchronous clear; wins over bit_valid
//   bit_valid       data_in is accepted on this edge
//   data_in         serial data bit
//   bit_out         oldest bit held in the packing register
//   bit_cnt         bits accepted toward the current word
//   word_vld        the bit accepted this edge completes a word
//   word_dat        completed word, including the bit accepted this edge
module word_delay_line_bit_packer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             data_in,
    output logic             bit_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_vld,
    output logic [WIDTH-1:0] word_dat
);

    logic [WIDTH-1:0] pack_q;
    logic [WIDTH-1:0] pack_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             last_bit;

    assign accept   = bit_valid && !clr;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Packing register with the incoming bit shifted in. The first bit of a
    // word travels furthest, so it ends up at the MSB or LSB as selected.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {pack_q[WIDTH-2:0], data_in};
        end else begin
            shifted = {data_in, pack_q[WIDTH-1:1]};
        end
    end

    // The packing register is not cleared on word completion: it keeps
    // shifting, so BIT_OUT always shows the bit accepted WIDTH bits ago.
    always_comb begin
        pack_d = pack_q;
        if (clr) begin
            pack_d = '0;
        end else if (bit_valid) begin
            pack_d = shifted;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (bit_valid) begin
            if (last_bit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_vld = accept && last_bit;
    assign word_dat = shifted;
    assign bit_cnt  = cnt_q;
    assign bit_out  = MSB_FIRST ? pack_q[WIDTH-1] : pack_q[0];

endmodule

// File: rtl/word_delay_line.sv
// Serial-to-word packer feeding a DEPTH-stage word delay line with a runtime tap.
// Latency: a word is at stage 0 the edge it completes; at WORD_OUT after DEPTH completions.
// Backpressure: none; the line advances only on word completion, never stalls input.
//
// Ports:
//   CLK, RST        clock and asynchronous active-high reset
//   CLR             synchronous clear, same end state as RST, wins over BIT_VALID
//   BIT_VALID       DATA_IN accepted on this edge
//   DATA_IN         serial data bit
//   TAP_SEL         stage index driving TAP_OUT / TAP_VALID
//   BIT_OUT         oldest bit in the packing register
//   BIT_CNT         bits accepted toward the current word
//   WORD_STB        one-cycle pulse after a word entered stage 0
//   WORD_OUT        stage DEPTH-1; WORD_OUT_VALID when the line is full
//   TAP_OUT         stage TAP_SEL; TAP_VALID when that stage holds a real word
//   FILL            number of valid stages, saturating at DEPTH
module word_delay_line
    import word_delay_line_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TAP_W     = clog2_min1(DEPTH)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CLR,
    input  logic                       BIT_VALID,
    input  logic                       DATA_IN,
    input  logic [TAP_W-1:0]           TAP_SEL,
    output logic                       BIT_OUT,
    output logic [$clog2(WIDTH):0]     BIT_CNT,
    output logic                       WORD_STB,
    output logic [WIDTH-1:0]           WORD_OUT,
    output logic                       WORD_OUT_VALID,
    output logic [WIDTH-1:0]           TAP_OUT,
    output logic                       TAP_VALID,
    output logic [$clog2(DEPTH+1)-1:0] FILL
);

    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic             word_vld;
    logic [WIDTH-1:0] word_dat;

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              word_stb_q;
    logic              word_stb_d;

    // Current contents of every stage, gathered for the output and tap muxes.
    logic [WIDTH-1:0] stage_arr [DEPTH];

    logic [WIDTH-1:0] tap_dat;
    logic             tap_vld;

    word_delay_line_bit_packer #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_bit_packer (
        .clk       (CLK),
        .rst       (RST),
        .clr       (CLR),
        .bit_valid (BIT_VALID),
        .data_in   (DATA_IN),
        .bit_out   (BIT_OUT),
        .bit_cnt   (BIT_CNT),
        .word_vld  (word_vld),
        .word_dat  (word_dat)
    );

    // Word stages. Every stage shifts together on a completion; stages past
    // the fill level hold zero because zeros are what shifted into them.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] shift_in;
        logic [WIDTH-1:0] stg_q;
        logic [WIDTH-1:0] stg_d;

        if (gi == 0) begin : g_head
            assign shift_in = word_dat;
        end else begin : g_body
            assign shift_in = stage_arr[gi-1];
        end

        always_comb begin
            stg_d = stg_q;
            if (CLR) begin
                stg_d = '0;
            end else if (word_vld) begin
                stg_d = shift_in;
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                stg_q <= '0;
            end else begin
                stg_q <= stg_d;
            end
        end

        assign stage_arr[gi] = stg_q;
    end

    // Fill level counts completions since reset/clear and saturates once the
    // oldest word starts falling off the end.
    always_comb begin
        fill_d = fill_q;
        if (CLR) begin
            fill_d = '0;
        end else if (word_vld && (fill_q != FILL_W'(DEPTH))) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    // word_vld is already suppressed by CLR inside the packer.
    always_comb begin
        word_stb_d = word_vld;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_q     <= '0;
            word_stb_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            word_stb_q <= word_stb_d;
        end
    end

    // Tap mux: an out-of-range select matches no stage and reads zero, so a
    // non-power-of-two DEPTH never aliases or produces X.
    always_comb begin
        tap_dat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (TAP_SEL == TAP_W'(k)) begin
                tap_dat = stage_arr[k];
            end
        end
    end

    // fill_q never exceeds DEPTH, so this is also false for any select >= DEPTH.
    assign tap_vld = (32'(TAP_SEL) < 32'(fill_q));

    assign WORD_STB       = word_stb_q;
    assign WORD_OUT       = stage_arr[DEPTH-1];
    assign WORD_OUT_VALID = (fill_q == FILL_W'(DEPTH));
    assign TAP_OUT        = tap_dat;
    assign TAP_VALID      = tap_vld;
    assign FILL           = fill_q;

endmodule

// File: tb/tb_word_delay_line.sv
// Self-checking bench: three configurations (8x12 MSB-first, 8x12 LSB-first,
// 2x1 MSB-first) share one serial stimulus and are compared every cycle
// against a queue-based model, plus literal expectations for key points.
module tb_word_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       clr;
    logic       bit_valid;
    logic       data_in;
    logic [3:0] tap_sel;
    logic       tap_sel_d1;

    logic       m_bit_out, m_word_stb, m_wov, m_tap_valid;
    logic [3:0] m_bit_cnt, m_fill;
    logic [7:0] m_word_out, m_tap_out;

    logic       l_bit_out, l_word_stb, l_wov, l_tap_valid;
    logic [3:0] l_bit_cnt, l_fill;
    logic [7:0] l_word_out, l_tap_out;

    logic       d_bit_out, d_word_stb, d_wov, d_tap_valid;
    logic [1:0] d_bit_cnt;
    logic       d_fill;
    logic [1:0] d_word_out, d_tap_out;

    int n_tests = 0;
    int n_fail  = 0;

    word_delay_line #(.WIDTH(8), .DEPTH(12), .MSB_FIRST(1'b1)) dut_m (
        .CLK(clk), .RST(rst), .CLR(clr), .BIT_VALID(bit_valid), .DATA_IN(data_in),
        .TAP_SEL(tap_sel), .BIT_OUT(m_bit_out), .BIT_CNT(m_bit_cnt),
        .WORD_STB(m_word_stb), .WORD_OUT(m_word_out), .WORD_OUT_VALID(m_wov),
        .TAP_OUT(m_tap_out), .TAP_VALID(m_tap_valid), .FILL(m_fill)
    );

    word_delay_line #(.WIDTH(8), .DEPTH(12), .MSB_FIRST(1'b0)) dut_l (
        .CLK(clk), .RST(rst), .CLR(clr), .BIT_VALID(bit_valid), .DATA_IN(data_in),
        .TAP_SEL(tap_sel), .BIT_OUT(l_bit_out), .BIT_CNT(l_bit_cnt),
        .WORD_STB(l_word_stb), .WORD_OUT(l_word_out), .WORD_OUT_VALID(l_wov),
        .TAP_OUT(l_tap_out), .TAP_VALID(l_tap_valid), .FILL(l_fill)
    );

    word_delay_line #(.WIDTH(2), .DEPTH(1), .MSB_FIRST(1'b1)) dut_d1 (
        .CLK(clk), .RST(rst), .CLR(clr), .BIT_VALID(bit_valid), .DATA_IN(data_in),
        .TAP_SEL(tap_sel_d1), .BIT_OUT(d_bit_out), .BIT_CNT(d_bit_cnt),
        .WORD_STB(d_word_stb), .WORD_OUT(d_word_out), .WORD_OUT_VALID(d_wov),
        .TAP_OUT(d_tap_out), .TAP_VALID(d_tap_valid), .FILL(d_fill)
    );

    // ---------------- model ----------------
    // Recent accepted bits (oldest first), bits toward the current word, and
    // completed words newest-first stored in first-bit-is-MSB order.
    bit         last8[$];
    int         cnt8;
    logic [7:0] hist[$];
    bit         stb8;
    bit         last2[$];
    int         cnt2;
    logic [1:0] w2;
    bit         v2;
    bit         stb2;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = x[7-j];
        return r;
    endfunction

    task automatic model_clear();
        last8.delete(); hist.delete(); last2.delete();
        cnt8 = 0; cnt2 = 0; stb8 = 0; stb2 = 0; w2 = 2'b00; v2 = 0;
    endtask

    task automatic model_edge();
        logic [7:0] w;
        if (clr) begin
            model_clear();
        end else begin
            stb8 = 0;
            stb2 = 0;
            if (bit_valid) begin
                last8.push_back(data_in);
                if (last8.size() > 8) void'(last8.pop_front());
                cnt8++;
                if (cnt8 == 8) begin
                    for (int j = 0; j < 8; j++) w[7-j] = last8[j];
                    hist.push_front(w);
                    if (hist.size() > 12) void'(hist.pop_back());
                    cnt8 = 0;
                    stb8 = 1;
                end
                last2.push_back(data_in);
                if (last2.size() > 2) void'(last2.pop_front());
                cnt2++;
                if (cnt2 == 2) begin
                    w2   = {last2[0], last2[1]};
                    v2   = 1;
                    cnt2 = 0;
                    stb2 = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all three DUTs against the model.
    task automatic check_cycle();
        int         k;
        int         n;
        logic [7:0] tm;
        logic [7:0] wm;
        bit         tv;
        bit         bo8;
        bit         bo2;
        k   = int'(tap_sel);
        n   = hist.size();
        tm  = (k < n) ? hist[k] : 8'h00;
        tv  = (k < n);
        wm  = (n == 12) ? hist[11] : 8'h00;
        bo8 = (last8.size() == 8) ? last8[0] : 1'b0;
        bo2 = (last2.size() == 2) ? last2[0] : 1'b0;

        chk("m.bit_out",   m_bit_out,   bo8);
        chk("m.bit_cnt",   m_bit_cnt,   cnt8);
        chk("m.word_stb",  m_word_stb,  stb8);
        chk("m.fill",      m_fill,      n);
        chk("m.word_out",  m_word_out,  wm);
        chk("m.wov",       m_wov,       (n == 12));
        chk("m.tap_out",   m_tap_out,   tm);
        chk("m.tap_valid", m_tap_valid, tv);

        chk("l.bit_out",   l_bit_out,   bo8);
        chk("l.bit_cnt",   l_bit_cnt,   cnt8);
        chk("l.word_stb",  l_word_stb,  stb8);
        chk("l.fill",      l_fill,      n);
        chk("l.word_out",  l_word_out,  rev8(wm));
        chk("l.wov",       l_wov,       (n == 12));
        chk("l.tap_out",   l_tap_out,   rev8(tm));
        chk("l.tap_valid", l_tap_valid, tv);

        chk("d.bit_out",   d_bit_out,   bo2);
        chk("d.bit_cnt",   d_bit_cnt,   cnt2);
        chk("d.word_stb",  d_word_stb,  stb2);
        chk("d.fill",      d_fill,      v2);
        chk("d.word_out",  d_word_out,  w2);
        chk("d.wov",       d_wov,       v2);
        chk("d.tap_out",   d_tap_out,   (tap_sel_d1 == 1'b0) ? w2 : 2'b00);
        chk("d.tap_valid", d_tap_valid, (tap_sel_d1 == 1'b0) && v2);
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input bit c, input bit v, input bit d);
        clr = c; bit_valid = v; data_in = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        clr = 1'b0; bit_valid = 1'b0; data_in = 1'b0;
    endtask

    // Sends a byte first-bit-first from bit 7, with idle cycles after each bit.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int j = 7; j >= 0; j--) begin
            step(1'b0, 1'b1, b[j]);
            repeat (gap) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Asynchronous reset pulse placed between a falling and a rising edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        model_clear();
        #1;
        check_cycle();
        chk("rst.m_bit_cnt", m_bit_cnt, 0);
        chk("rst.m_fill",    m_fill,    0);
        chk("rst.m_tap_out", m_tap_out, 0);
        chk("rst.l_word_out", l_word_out, 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; bit_valid = 1'b0; data_in = 1'b0;
        tap_sel = 4'd0; tap_sel_d1 = 1'b0;
        model_clear();
        #3;
        check_cycle();
        chk("init.m_fill",     m_fill,     0);
        chk("init.m_bit_out",  m_bit_out,  0);
        chk("init.m_word_stb", m_word_stb, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1,0,1,0,0,1,0,1 -> 0xA5 in either bit order.
        send_byte(8'hA5, 0);
        chk("a5.m_tap_out",   m_tap_out,   8'hA5);
        chk("a5.l_tap_out",   l_tap_out,   8'hA5);
        chk("a5.m_word_stb",  m_word_stb,  1);
        chk("a5.m_fill",      m_fill,      1);
        chk("a5.m_tap_valid", m_tap_valid, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("a5.stb_drop",    m_word_stb,  0);
        tap_sel = 4'd1;
        #1;
        check_cycle();
        chk("a5.tap1_valid",  m_tap_valid, 0);
        tap_sel = 4'd0;

        // First bit 1, rest 0.
        send_byte(8'h80, 0);
        chk("x80.m_tap_out", m_tap_out, 8'h80);
        chk("x80.l_tap_out", l_tap_out, 8'h01);
        chk("x80.m_fill",    m_fill,    2);

        // Three bits, then an asynchronous reset discards everything.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("mid.m_bit_cnt", m_bit_cnt, 3);
        async_reset();

        // Thirteen words with idle gaps between bits.
        for (int w = 0; w < 13; w++) begin
            send_byte(8'(w), 1);
            if (w == 10) chk("fill11.m_wov", m_wov, 0);
            if (w == 11) begin
                chk("fill12.m_wov",      m_wov,      1);
                chk("fill12.m_word_out", m_word_out, 8'h00);
            end
        end
        chk("full.m_word_out", m_word_out, 8'h01);
        chk("full.m_fill",     m_fill,     12);

        // Tap sweep over the full line including out-of-range selects.
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b0, 1'b0);
            tap_sel    = 4'(k);
            tap_sel_d1 = k[0];
            #1;
            check_cycle();
            chk("sweep.tap_out",   m_tap_out,   (k < 12) ? 8'(12 - k) : 8'h00);
            chk("sweep.tap_valid", m_tap_valid, (k < 12));
        end
        tap_sel = 4'd0;
        tap_sel_d1 = 1'b0;

        // Three stale bits, then CLR together with BIT_VALID.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("clr.m_bit_cnt", m_bit_cnt, 0);
        chk("clr.m_fill",    m_fill,    0);
        chk("clr.l_fill",    l_fill,    0);
        chk("clr.d_fill",    d_fill,    0);
        send_byte(8'h3D, 0);
        chk("clean.m_tap_out", m_tap_out, 8'h3D);
        chk("clean.l_tap_out", l_tap_out, 8'hBC);
        chk("clean.m_fill",    m_fill,    1);
        chk("clean.d_word_out", d_word_out, 2'b01);
        chk("clean.d_wov",      d_wov,      1);
        tap_sel_d1 = 1'b1;
        #1;
        check_cycle();
        chk("d1.oor_tap_out",   d_tap_out,   2'b00);
        chk("d1.oor_tap_valid", d_tap_valid, 0);
        tap_sel_d1 = 1'b0;

        // A partial word survives a long idle stretch.
        step(1'b0, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("idle.m_bit_cnt", m_bit_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
